// File: rtl/interrupt_arbiter.sv
// rtl/interrupt_arbiter.sv - interrupt request latch, mask, priority arbiter and CPU hand-off FSM
//
// Latches rising edges on peripheral request lines as pending, qualifies them
// with a software enable mask, picks the lowest-index eligible source and
// presents a single registered request plus handler vector to the control unit.
// The request is held frozen until the control unit acknowledges it.
//
// Ports:
//   clk        in   system clock
//   reset      in   asynchronous active-high reset
//   irq_in     in   [IRQ_COUNT]     peripheral request levels (clk-synchronous)
//   global_en  in   global interrupt enable (SREG I flag)
//   irq        out  request to control unit (registered)
//   vector     out  [I_ADDR_WIDTH]  handler address, valid while irq=1 (registered)
//   ack        in   one-cycle acceptance pulse from control unit
//   io_addr    in   [IO_ADDR_WIDTH] I/O register address
//   io_wdata   in   [8]             I/O write data
//   io_we      in   I/O write strobe
//   io_oe      in   I/O read strobe
//   io_rdata   out  [8]             I/O read data, 0 when not selected
module interrupt_arbiter #(
  parameter int                         IRQ_COUNT     = 8,
  parameter int                         I_ADDR_WIDTH  = 10,
  parameter logic [I_ADDR_WIDTH-1:0]    VECTOR_BASE   = 10'd1,
  parameter logic [I_ADDR_WIDTH-1:0]    VECTOR_STRIDE = 10'd1,
  parameter int                         IO_ADDR_WIDTH = 6,
  parameter logic [IO_ADDR_WIDTH-1:0]   MASK_ADDR     = 6'h3B,
  parameter logic [IO_ADDR_WIDTH-1:0]   PEND_ADDR     = 6'h3A
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [IRQ_COUNT-1:0]     irq_in,
  input  logic                     global_en,
  output logic                     irq,
  output logic [I_ADDR_WIDTH-1:0]  vector,
  input  logic                     ack,
  input  logic [IO_ADDR_WIDTH-1:0] io_addr,
  input  logic [7:0]               io_wdata,
  input  logic                     io_we,
  input  logic                     io_oe,
  output logic [7:0]               io_rdata
);

  localparam int IDX_W = (IRQ_COUNT > 1) ? $clog2(IRQ_COUNT) : 1;
  // Number of sources visible through the 8-bit I/O registers.
  localparam int N_IO  = (IRQ_COUNT < 8) ? IRQ_COUNT : 8;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                    r_state;
  state_t                    w_state_next;
  logic [IRQ_COUNT-1:0]      r_irq_prev;
  logic [IRQ_COUNT-1:0]      r_pending;
  logic [IRQ_COUNT-1:0]      r_imsk;
  logic [IDX_W-1:0]          r_idx;
  logic [I_ADDR_WIDTH-1:0]   r_vector;
  logic                      r_irq;

  logic [IRQ_COUNT-1:0]      w_edge;
  logic [IRQ_COUNT-1:0]      w_eligible;
  logic [IRQ_COUNT-1:0]      w_wbits;
  logic [IRQ_COUNT-1:0]      w_clr;
  logic [IRQ_COUNT-1:0]      w_pending_next;
  logic [IDX_W-1:0]          w_win_idx;
  logic [I_ADDR_WIDTH-1:0]   w_win_vec;
  logic                      w_latch;
  logic                      w_ack_clr;
  logic                      w_mask_sel;
  logic                      w_pend_sel;
  logic [7:0]                w_imsk_rd;
  logic [7:0]                w_pend_rd;

  assign w_mask_sel = (io_addr == MASK_ADDR);
  assign w_pend_sel = (io_addr == PEND_ADDR);

  // Only the low N_IO sources are reachable from the 8-bit data bus.
  assign w_wbits   = IRQ_COUNT'(io_wdata[N_IO-1:0]);
  assign w_imsk_rd = 8'(r_imsk[N_IO-1:0]);
  assign w_pend_rd = 8'(r_pending[N_IO-1:0]);

  assign w_edge     = irq_in & ~r_irq_prev;
  assign w_eligible = r_pending & r_imsk;

  // Descending scan so the lowest set index is the last assignment and wins.
  always_comb begin
    w_win_idx = '0;
    w_win_vec = '0;
    for (int i = IRQ_COUNT - 1; i >= 0; i--) begin
      if (w_eligible[i]) begin
        w_win_idx = IDX_W'(i);
        w_win_vec = VECTOR_BASE + VECTOR_STRIDE * I_ADDR_WIDTH'(i);
      end
    end
  end

  // Clear sources: software IPEND write-1-to-clear and the serviced source on ack.
  // Set edges are OR-ed in after the clear so a same-cycle edge always wins.
  always_comb begin
    w_clr = '0;
    if (io_we && w_pend_sel) begin
      w_clr = w_wbits;
    end
    for (int i = 0; i < IRQ_COUNT; i++) begin
      if (w_ack_clr && (r_idx == IDX_W'(i))) begin
        w_clr[i] = 1'b1;
      end
    end
    w_pending_next = (r_pending & ~w_clr) | w_edge;
  end

  // Next-state logic. Once in REQ nothing but ack moves the FSM, which keeps
  // the request and vector frozen regardless of mask/pending/global_en.
  always_comb begin
    w_state_next = r_state;
    w_latch      = 1'b0;
    w_ack_clr    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (global_en && (w_eligible != '0)) begin
          w_latch      = 1'b1;
          w_state_next = S_REQ;
        end
      end
      S_REQ: begin
        if (ack) begin
          w_ack_clr    = 1'b1;
          w_state_next = S_DONE;
        end
      end
      S_DONE: begin
        w_state_next = S_IDLE;
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_irq_prev <= '0;
      r_pending  <= '0;
      r_imsk     <= '0;
      r_idx      <= '0;
      r_vector   <= '0;
      r_irq      <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_irq_prev <= irq_in;
      r_pending  <= w_pending_next;
      r_irq      <= (w_state_next == S_REQ);
      if (io_we && w_mask_sel) begin
        r_imsk <= w_wbits;
      end
      if (w_latch) begin
        r_idx    <= w_win_idx;
        r_vector <= w_win_vec;
      end
    end
  end

  assign irq    = r_irq;
  assign vector = r_vector;

  always_comb begin
    io_rdata = 8'h00;
    if (io_oe) begin
      if (w_mask_sel) begin
        io_rdata = w_imsk_rd;
      end else if (w_pend_sel) begin
        io_rdata = w_pend_rd;
      end
    end
  end

endmodule
